// File: rtl/logger_pkg.sv
// ---------------------------------------------------------------------------
// logger_pkg
// Shared constants for the sample logger: page geometry, the pad byte used
// when a partial page is flushed, the writer-FSM state encodings and the
// per-buffer status encodings used by page_cache_builder.
// ---------------------------------------------------------------------------
package logger_pkg;

  localparam int PAGE_BYTES = 64;   // bytes per EEPROM page
  localparam int ADDR_W     = 15;   // 24LC256 byte-address width

  localparam logic [7:0] PAD_BYTE = 8'hFF;  // erased-EEPROM value

  // Writer FSM states
  localparam logic [1:0] WR_IDLE   = 2'd0;
  localparam logic [1:0] WR_LAUNCH = 2'd1;
  localparam logic [1:0] WR_BUSY   = 2'd2;

  // Ping-pong buffer status
  localparam logic [1:0] BUF_FREE    = 2'd0;  // unused, may be claimed for filling
  localparam logic [1:0] BUF_FILLING = 2'd1;  // currently receiving samples
  localparam logic [1:0] BUF_FULL    = 2'd2;  // complete, waiting for the writer
  localparam logic [1:0] BUF_WRITING = 2'd3;  // copied to CACHE, EEPROM write in flight

endpackage

// File: rtl/page_buffer.sv
// ---------------------------------------------------------------------------
// page_buffer
// One page of sample storage: PAGE_BYTES x 8 register file with a single
// byte-write port, a bulk pad port and a flat read-out bus.
//
// Ports:
//   CLK_800KHz  in   system clock, rising edge
//   RESET       in   asynchronous active-low reset; clears every byte to 0
//   wrEn        in   write wrData at byte wrIdx this edge
//   wrIdx       in   byte index for the write
//   wrData      in   byte to store
//   padEn       in   overwrite every byte with index >= padFrom by PAD_BYTE
//   padFrom     in   first padded index (PAGE_BYTES means "pad nothing")
//   pageData    out  whole page, byte k at bits [8k+7:8k]
// ---------------------------------------------------------------------------
module page_buffer #(
  parameter int PAGE_BYTES = 64,
  parameter int IDX_W      = $clog2(PAGE_BYTES)
) (
  input  logic                    CLK_800KHz,
  input  logic                    RESET,
  input  logic                    wrEn,
  input  logic [IDX_W-1:0]        wrIdx,
  input  logic [7:0]              wrData,
  input  logic                    padEn,
  input  logic [IDX_W:0]          padFrom,
  output logic [8*PAGE_BYTES-1:0] pageData
);

  import logger_pkg::*;

  logic [7:0] mem [PAGE_BYTES];

  // NOTE: this storage is reset on purpose -- the page must read back as all
  // zeros after reset -- which makes it flops rather than an inferable RAM.
  always_ff @(posedge CLK_800KHz or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < PAGE_BYTES; k++) mem[k] <= '0;
    end else begin
      for (int k = 0; k < PAGE_BYTES; k++) begin
        // The written byte and the padded range never overlap: padding
        // starts after the byte accepted on the same edge.
        if (wrEn && wrIdx == IDX_W'(k))
          mem[k] <= wrData;
        else if (padEn && (IDX_W+1)'(k) >= padFrom)
          mem[k] <= PAD_BYTE;
      end
    end
  end

  for (genvar k = 0; k < PAGE_BYTES; k++) begin : g_out
    assign pageData[8*k +: 8] = mem[k];
  end

endmodule

// File: rtl/page_cache_builder.sv
// ---------------------------------------------------------------------------
// page_cache_builder
// Collects sample bytes into two ping-pong page buffers and hands complete
// pages to the I2C EEPROM writer. One buffer fills while the other is being
// written, so sampling continues through an EEPROM write cycle.
//
// Ports:
//   CLK_800KHz    in   system clock, rising edge
//   RESET         in   asynchronous active-low reset
//   SAMPLE_DATA   in   sample byte
//   SAMPLE_VALID  in   SAMPLE_DATA valid this cycle
//   SAMPLE_READY  out  a byte can be accepted this cycle
//   CACHE         out  page under write, byte k at bits [8k+7:8k]
//   MEM_ADDR      out  EEPROM address of CACHE byte 0
//   WR_START      out  one-cycle pulse: CACHE/MEM_ADDR valid, begin write
//   WR_DONE       in   one-cycle pulse from writer: page committed
//   FLUSH         in   (PAGE_FLUSH_EN only) pad partial page with 0xFF, launch it
//   OVERRUN       out  sticky: at least one sample dropped
//   DROP_COUNT    out  dropped samples, saturating at 255
//
// Build option: define PAGE_FLUSH_EN to add the FLUSH input.
// ---------------------------------------------------------------------------
module page_cache_builder #(
  parameter int                PAGE_BYTES = logger_pkg::PAGE_BYTES,
  parameter int                ADDR_W     = logger_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic                    CLK_800KHz,
  input  logic                    RESET,
  input  logic [7:0]              SAMPLE_DATA,
  input  logic                    SAMPLE_VALID,
  output logic                    SAMPLE_READY,
  output logic [8*PAGE_BYTES-1:0] CACHE,
  output logic [ADDR_W-1:0]       MEM_ADDR,
  output logic                    WR_START,
  input  logic                    WR_DONE,
`ifdef PAGE_FLUSH_EN
  input  logic                    FLUSH,
`endif
  output logic                    OVERRUN,
  output logic [7:0]              DROP_COUNT
);

  import logger_pkg::*;

  localparam int                IDX_W     = $clog2(PAGE_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PAGE_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(PAGE_BYTES);

  logic [IDX_W-1:0]        idx, idxNext;
  logic                    fillSel, fillSelNext, otherSel;
  logic                    launchSel;   // oldest buffer awaiting / under write
  logic [1:0]              bufStatus  [2];
  logic [1:0]              statusNext [2];
  logic [1:0]              wrState;
  logic                    accept, flushHit, pageDone, releaseHit, otherFree;
  logic [IDX_W:0]          padFrom;
  logic [1:0]              bufWrEn, padEn;
  logic [8*PAGE_BYTES-1:0] bufData [2];

  assign otherSel = ~fillSel;

  // Stall only when the fill buffer is complete and has nowhere to go.
  assign SAMPLE_READY = !(bufStatus[fillSel] == BUF_FULL && bufStatus[otherSel] != BUF_FREE);
  assign accept       = SAMPLE_VALID && SAMPLE_READY;

`ifdef PAGE_FLUSH_EN
  // A flush needs at least one real byte, counting one accepted this edge.
  assign flushHit = FLUSH && bufStatus[fillSel] == BUF_FILLING && (accept || idx != '0);
`else
  assign flushHit = 1'b0;
`endif

  assign pageDone   = (accept && idx == LAST_IDX) || flushHit;
  assign releaseHit = (wrState == WR_BUSY) && WR_DONE;
  // A buffer released on this edge is already usable for the fill switch.
  assign otherFree  = (bufStatus[otherSel] == BUF_FREE) || (releaseHit && launchSel == otherSel);
  assign padFrom    = accept ? {1'b0, idx} + (IDX_W+1)'(1) : {1'b0, idx};

  for (genvar b = 0; b < 2; b++) begin : g_buf
    assign bufWrEn[b] = accept   && (fillSel == 1'(b));
    assign padEn[b]   = flushHit && (fillSel == 1'(b));

    page_buffer #(.PAGE_BYTES(PAGE_BYTES)) u_buf (
      .CLK_800KHz (CLK_800KHz),
      .RESET      (RESET),
      .wrEn       (bufWrEn[b]),
      .wrIdx      (idx),
      .wrData     (SAMPLE_DATA),
      .padEn      (padEn[b]),
      .padFrom    (padFrom),
      .pageData   (bufData[b])
    );
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned (which would infer a latch); blocking '=' is correct here.
  always_comb begin
    statusNext[0] = bufStatus[0];
    statusNext[1] = bufStatus[1];
    fillSelNext   = fillSel;
    idxNext       = idx;
    if (accept) idxNext = idx + IDX_W'(1);
    if (wrState == WR_LAUNCH) statusNext[launchSel] = BUF_WRITING;
    if (releaseHit)           statusNext[launchSel] = BUF_FREE;
    if (pageDone)             statusNext[fillSel]   = BUF_FULL;
    // Move the fill pointer as soon as a complete page has a free partner,
    // either on the completing edge or later when the writer releases one.
    if (pageDone || bufStatus[fillSel] == BUF_FULL) begin
      idxNext = '0;
      if (otherFree) begin
        fillSelNext          = otherSel;
        statusNext[otherSel] = BUF_FILLING;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_800KHz or negedge RESET) begin
    if (!RESET) begin
      idx          <= '0;
      fillSel      <= 1'b0;
      launchSel    <= 1'b0;
      bufStatus[0] <= BUF_FILLING;
      bufStatus[1] <= BUF_FREE;
      wrState      <= WR_IDLE;
      WR_START     <= 1'b0;
      CACHE        <= '0;
      MEM_ADDR     <= START_ADDR;
      OVERRUN      <= 1'b0;
      DROP_COUNT   <= '0;
    end else begin
      idx          <= idxNext;
      fillSel      <= fillSelNext;
      bufStatus[0] <= statusNext[0];
      bufStatus[1] <= statusNext[1];
      WR_START     <= 1'b0;

      case (wrState)
        WR_IDLE:   if (bufStatus[launchSel] == BUF_FULL) wrState <= WR_LAUNCH;
        WR_LAUNCH: begin
          CACHE    <= bufData[launchSel];
          WR_START <= 1'b1;
          wrState  <= WR_BUSY;
        end
        WR_BUSY:   if (WR_DONE) begin
          MEM_ADDR  <= MEM_ADDR + ADDR_STEP;  // wraps at 2^ADDR_W
          launchSel <= ~launchSel;            // pages complete alternately
          wrState   <= WR_IDLE;
        end
        default:   wrState <= WR_IDLE;
      endcase

      if (SAMPLE_VALID && !SAMPLE_READY) begin
        OVERRUN <= 1'b1;
        if (DROP_COUNT != 8'hFF) DROP_COUNT <= DROP_COUNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_page_cache_builder.sv
// ---------------------------------------------------------------------------
// tb_page_cache_builder
// Two instances share all stimulus: dut1 starts at address 0, dut2 at 0x7FC0
// so address wrap is exercised alongside normal operation. A reference model
// tracks pages as byte queues: a page completes at 64 bytes (or on flush,
// padded with 0xFF), at most two complete-but-uncommitted pages may exist,
// and a page launches two edges after it becomes eligible for the writer.
// ---------------------------------------------------------------------------
module tb_page_cache_builder;

  localparam int              PB     = 64;
  localparam int              AW     = 15;
  localparam logic [AW-1:0]   START2 = 15'h7FC0;

  logic            CLK_800KHz;
  logic            RESET;
  logic [7:0]      SAMPLE_DATA;
  logic            SAMPLE_VALID;
  logic            WR_DONE;
`ifdef PAGE_FLUSH_EN
  logic            FLUSH;
`endif

  logic            ready1, ready2, start1, start2, over1, over2;
  logic [8*PB-1:0] cache1, cache2;
  logic [AW-1:0]   addr1, addr2;
  logic [7:0]      drops1, drops2;

  page_cache_builder #(.PAGE_BYTES(PB), .ADDR_W(AW), .START_ADDR('0)) dut1 (
    .CLK_800KHz(CLK_800KHz), .RESET(RESET), .SAMPLE_DATA(SAMPLE_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_READY(ready1), .CACHE(cache1),
    .MEM_ADDR(addr1), .WR_START(start1), .WR_DONE(WR_DONE),
`ifdef PAGE_FLUSH_EN
    .FLUSH(FLUSH),
`endif
    .OVERRUN(over1), .DROP_COUNT(drops1));

  page_cache_builder #(.PAGE_BYTES(PB), .ADDR_W(AW), .START_ADDR(START2)) dut2 (
    .CLK_800KHz(CLK_800KHz), .RESET(RESET), .SAMPLE_DATA(SAMPLE_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_READY(ready2), .CACHE(cache2),
    .MEM_ADDR(addr2), .WR_START(start2), .WR_DONE(WR_DONE),
`ifdef PAGE_FLUSH_EN
    .FLUSH(FLUSH),
`endif
    .OVERRUN(over2), .DROP_COUNT(drops2));

  initial CLK_800KHz = 1'b0;
  always #5 CLK_800KHz = ~CLK_800KHz;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [7:0]      cur[$];     // bytes of the page being filled
  logic [8*PB-1:0] doneQ[$];   // complete, uncommitted pages, oldest first
  logic            busy;       // front page launched, awaiting WR_DONE
  int              edgeNo, startDue, mDrops;
  logic            mOverrun;
  logic [AW-1:0]   mAddr1, mAddr2;

  function automatic logic [8*PB-1:0] packPage();
    logic [8*PB-1:0] pg;
    pg = '0;
    for (int k = 0; k < PB; k++) pg[8*k +: 8] = (k < cur.size()) ? cur[k] : 8'hFF;
    return pg;
  endfunction

  task automatic modelReset();
    cur.delete(); doneQ.delete();
    busy = 1'b0; edgeNo = 0; startDue = -1; mDrops = 0; mOverrun = 1'b0;
    mAddr1 = '0; mAddr2 = START2;
  endtask

  // One clock: drive at a falling edge, update the model at the rising edge,
  // compare at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic done, input logic fl);
    logic mReady, expStart;
    mReady = (doneQ.size() < 2);
    SAMPLE_VALID = v; SAMPLE_DATA = d; WR_DONE = done;
`ifdef PAGE_FLUSH_EN
    FLUSH = fl;
`endif
    checks += 2;
    if (ready1 !== mReady) begin errors++; $display("FAIL ready1 t=%0t got=%b want=%b", $time, ready1, mReady); end
    if (ready2 !== mReady) begin errors++; $display("FAIL ready2 t=%0t got=%b want=%b", $time, ready2, mReady); end
    @(posedge CLK_800KHz);
    edgeNo++;
    if (done && busy) begin
      void'(doneQ.pop_front());
      busy = 1'b0; mAddr1 += AW'(PB); mAddr2 += AW'(PB);
    end
    if (v && mReady) cur.push_back(d);
    else if (v) begin mOverrun = 1'b1; if (mDrops < 255) mDrops++; end
    if (cur.size() == PB || (fl && cur.size() > 0)) begin
      doneQ.push_back(packPage());
      cur.delete();
    end
    expStart = 1'b0;
    if (startDue == edgeNo) begin expStart = 1'b1; busy = 1'b1; startDue = -1; end
    if (!busy && startDue < 0 && doneQ.size() > 0) startDue = edgeNo + 2;
    @(negedge CLK_800KHz);
    SAMPLE_VALID = 1'b0; WR_DONE = 1'b0;
`ifdef PAGE_FLUSH_EN
    FLUSH = 1'b0;
`endif
    checks += 8;
    if (start1 !== expStart) begin errors++; $display("FAIL wr_start1 t=%0t got=%b want=%b", $time, start1, expStart); end
    if (start2 !== expStart) begin errors++; $display("FAIL wr_start2 t=%0t got=%b want=%b", $time, start2, expStart); end
    if (over1 !== mOverrun) begin errors++; $display("FAIL overrun1 t=%0t got=%b want=%b", $time, over1, mOverrun); end
    if (over2 !== mOverrun) begin errors++; $display("FAIL overrun2 t=%0t got=%b want=%b", $time, over2, mOverrun); end
    if (drops1 !== 8'(mDrops)) begin errors++; $display("FAIL drops1 t=%0t got=%0d want=%0d", $time, drops1, mDrops); end
    if (drops2 !== 8'(mDrops)) begin errors++; $display("FAIL drops2 t=%0t got=%0d want=%0d", $time, drops2, mDrops); end
    if (addr1 !== mAddr1) begin errors++; $display("FAIL mem_addr1 t=%0t got=%h want=%h", $time, addr1, mAddr1); end
    if (addr2 !== mAddr2) begin errors++; $display("FAIL mem_addr2 t=%0t got=%h want=%h", $time, addr2, mAddr2); end
    if (busy) begin
      checks += 2;
      if (cache1 !== doneQ[0]) begin errors++; $display("FAIL cache1 t=%0t got=%h want=%h", $time, cache1, doneQ[0]); end
      if (cache2 !== doneQ[0]) begin errors++; $display("FAIL cache2 t=%0t got=%h want=%h", $time, cache2, doneQ[0]); end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    SAMPLE_VALID = 1'b0; WR_DONE = 1'b0;
`ifdef PAGE_FLUSH_EN
    FLUSH = 1'b0;
`endif
    #2 RESET = 1'b0;
    @(negedge CLK_800KHz);
    RESET = 1'b1;
    modelReset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    SAMPLE_VALID = 1'b0; SAMPLE_DATA = '0; WR_DONE = 1'b0;
`ifdef PAGE_FLUSH_EN
    FLUSH = 1'b0;
`endif
    RESET = 1'b0;
    @(negedge CLK_800KHz); @(negedge CLK_800KHz);
    checks += 8;
    if (ready1 !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", ready1); end
    if (start1 !== 1'b0) begin errors++; $display("FAIL rst_wr_start got=%b want=0", start1); end
    if (cache1 !== '0)   begin errors++; $display("FAIL rst_cache got=%h want=0", cache1); end
    if (addr1 !== '0)    begin errors++; $display("FAIL rst_addr1 got=%h want=0", addr1); end
    if (addr2 !== START2) begin errors++; $display("FAIL rst_addr2 got=%h want=%h", addr2, START2); end
    if (over1 !== 1'b0)  begin errors++; $display("FAIL rst_overrun got=%b want=0", over1); end
    if (drops1 !== 8'd0) begin errors++; $display("FAIL rst_drops got=%0d want=0", drops1); end
    if (ready2 !== 1'b1) begin errors++; $display("FAIL rst_ready2 got=%b want=1", ready2); end
    RESET = 1'b1;
    modelReset();
  endtask

  task automatic test_first_page();
    doReset();
    for (int i = 0; i < PB; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    idle(2);   // WR_START expected two edges after the 64th accept
    checks += 5;
    if (start1 !== 1'b1) begin errors++; $display("FAIL page1_wr_start got=%b want=1", start1); end
    if (cache1[7:0] !== 8'h00) begin errors++; $display("FAIL page1_byte0 got=%h want=00", cache1[7:0]); end
    if (cache1[511:504] !== 8'h3F) begin errors++; $display("FAIL page1_byte63 got=%h want=3f", cache1[511:504]); end
    if (addr1 !== 15'h0000) begin errors++; $display("FAIL page1_addr1 got=%h want=0000", addr1); end
    if (addr2 !== 15'h7FC0) begin errors++; $display("FAIL page1_addr2 got=%h want=7fc0", addr2); end
  endtask

  task automatic test_overrun();
    // Continues from test_first_page with the writer never finishing.
    for (int i = 0; i < PB; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    checks += 1;
    if (ready1 !== 1'b0) begin errors++; $display("FAIL overrun_ready got=%b want=0", ready1); end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    checks += 2;
    if (over1 !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b want=1", over1); end
    if (drops1 !== 8'd1) begin errors++; $display("FAIL overrun_count got=%0d want=1", drops1); end
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int i = 0; i < PB; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < PB - 1; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'h7F, 1'b1, 1'b0);  // 128th byte together with WR_DONE
    checks += 3;
    if (ready1 !== 1'b1) begin errors++; $display("FAIL same_edge_ready got=%b want=1", ready1); end
    if (drops1 !== 8'd0) begin errors++; $display("FAIL same_edge_drops got=%0d want=0", drops1); end
    if (over1 !== 1'b0)  begin errors++; $display("FAIL same_edge_overrun got=%b want=0", over1); end
    idle(2);
    checks += 3;
    if (start1 !== 1'b1) begin errors++; $display("FAIL page2_wr_start got=%b want=1", start1); end
    if (addr1 !== 15'h0040) begin errors++; $display("FAIL page2_addr1 got=%h want=0040", addr1); end
    if (addr2 !== 15'h0000) begin errors++; $display("FAIL wrap_addr2 got=%h want=0000", addr2); end
    idle(3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks += 2;
    if (addr1 !== 15'h0080) begin errors++; $display("FAIL page3_addr1 got=%h want=0080", addr1); end
    if (addr2 !== 15'h0040) begin errors++; $display("FAIL page3_addr2 got=%h want=0040", addr2); end
  endtask

  task automatic test_saturate();
    doReset();
    for (int i = 0; i < 2 * PB + 300; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    checks += 2;
    if (drops1 !== 8'd255) begin errors++; $display("FAIL saturate_count got=%0d want=255", drops1); end
    if (over1 !== 1'b1)    begin errors++; $display("FAIL saturate_overrun got=%b want=1", over1); end
  endtask

  task automatic test_reset_mid_write();
    doReset();
    for (int i = 0; i < 2 * PB + 1; i++) cycle(1'b1, 8'(8'h55 ^ i), 1'b0, 1'b0);
    idle(1);   // writer is busy, a drop has been recorded
    #2 RESET = 1'b0;
    #1;        // well before the next rising edge
    checks += 8;
    if (ready1 !== 1'b1) begin errors++; $display("FAIL async_ready got=%b want=1", ready1); end
    if (start1 !== 1'b0) begin errors++; $display("FAIL async_wr_start got=%b want=0", start1); end
    if (cache1 !== '0)   begin errors++; $display("FAIL async_cache got=%h want=0", cache1); end
    if (addr1 !== '0)    begin errors++; $display("FAIL async_addr1 got=%h want=0", addr1); end
    if (addr2 !== START2) begin errors++; $display("FAIL async_addr2 got=%h want=%h", addr2, START2); end
    if (over1 !== 1'b0)  begin errors++; $display("FAIL async_overrun got=%b want=0", over1); end
    if (drops1 !== 8'd0) begin errors++; $display("FAIL async_drops got=%0d want=0", drops1); end
    if (cache2 !== '0)   begin errors++; $display("FAIL async_cache2 got=%h want=0", cache2); end
    @(negedge CLK_800KHz);
    RESET = 1'b1;
    modelReset();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);  // stale WR_DONE must be ignored
    for (int i = 0; i < PB; i++) cycle(1'b1, 8'(i * 3), 1'b0, 1'b0);
    idle(4);
  endtask

`ifdef PAGE_FLUSH_EN
  task automatic test_flush();
    logic [8*PB-1:0] want;
    doReset();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);  // flush of an empty page is ignored
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);
    want = {{(PB-3){8'hFF}}, 8'hA3, 8'hA2, 8'hA1};
    checks += 2;
    if (start1 !== 1'b1) begin errors++; $display("FAIL flush_wr_start got=%b want=1", start1); end
    if (cache1 !== want) begin errors++; $display("FAIL flush_page got=%h want=%h", cache1, want); end
    cycle(1'b1, 8'hB1, 1'b0, 1'b1);  // byte and flush on the same edge
    idle(3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
  endtask
`endif

  task automatic test_random();
    doReset();
    for (int i = 0; i < 4000; i++) begin
      logic v, dn, fl;
      logic slow;
      slow = ((i / 800) % 2) == 1;
      v    = ($urandom_range(0, 9) < 7);
      if (busy) dn = ($urandom_range(0, slow ? 160 : 6) == 0);
      else      dn = ($urandom_range(0, 40) == 0);
`ifdef PAGE_FLUSH_EN
      fl = ($urandom_range(0, 150) == 0);
`else
      fl = 1'b0;
`endif
      cycle(v, 8'($urandom), dn, fl);
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_first_page();
    test_overrun();
    test_back_to_back();
    test_saturate();
    test_reset_mid_write();
`ifdef PAGE_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
